// File: rtl/vmc_param.sv
// Parametrised vending machine controller.
// Level inputs from switches are turned into single-cycle events by an
// internal edge register; the FSM walks IDLE -> SEL -> PAY -> DISP -> CHANGE.
// Credit saturates. Change is paid out greedily, one coin per cycle.
// A PAY phase with no coin activity for TIMEOUT_CYC cycles refunds the credit.
// All outputs come straight from flops.
module vmc_param #(
  parameter int                          NUM_ITEMS    = 4,
  parameter int                          ITEM_W       = 2,
  parameter int                          PRICE_W      = 6,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES      = {6'd7, 6'd25, 6'd20, 6'd15},
  parameter int                          CREDIT_W     = 7,
  parameter int                          TIMEOUT_CYC  = 20,
  parameter int                          DISPENSE_CYC = 2
) (
  input  logic                CLOCK,
  input  logic                nRESET,
  input  logic                START,
  input  logic                SELECT,
  input  logic                OK,
  input  logic                CANCEL,
  input  logic                COIN_1,
  input  logic                COIN_5,
  input  logic                COIN_10,
  output logic [ITEM_W-1:0]   ITEM,
  output logic [CREDIT_W-1:0] CREDIT,
  output logic                DISPENSE,
  output logic                C1,
  output logic                C5,
  output logic                C10
);

  typedef enum logic [2:0] {IDLE, SEL, PAY, DISP, CHANGE} state_t;

  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int DCW = (DISPENSE_CYC > 1) ? $clog2(DISPENSE_CYC) : 1;
  localparam int SW  = CREDIT_W + 5;
  localparam logic [CREDIT_W-1:0] CMAX = {CREDIT_W{1'b1}};

  // Event bit order: 0 START, 1 SELECT, 2 OK, 3 CANCEL, 4 COIN_1, 5 COIN_5, 6 COIN_10
  logic [6:0] in_now, in_q, ev;
  assign in_now = {COIN_10, COIN_5, COIN_1, CANCEL, OK, SELECT, START};

  state_t               state_q, state_d;
  logic [ITEM_W-1:0]    item_q, item_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [TCW-1:0]       tmo_q, tmo_d, tmo_inc;
  logic [DCW-1:0]       dcnt_q, dcnt_d;
  logic                 disp_q, c1_q, c5_q, c10_q;
  logic                 c1_d, c5_d, c10_d;
  logic [PRICE_W-1:0]   price;
  logic [CREDIT_W-1:0]  price_ext;
  logic [SW-1:0]        sum_w;
  logic [CREDIT_W-1:0]  sum_sat;
  logic                 any_coin;

  // Input history and registered rising-edge events; a held level yields one event.
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      in_q <= '0;
      ev   <= '0;
    end else begin
      in_q <= in_now;
      ev   <= in_now & ~in_q;
    end
  end

  // Price of the currently selected item.
  always_comb begin
    price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item_q == ITEM_W'(i)) price = PRICES[i*PRICE_W +: PRICE_W];
    end
  end

  assign price_ext = CREDIT_W'(price);
  assign any_coin  = ev[4] | ev[5] | ev[6];
  assign tmo_inc   = any_coin ? '0 : tmo_q + TCW'(1);

  // Credit plus all coins seen this cycle, clamped to the register maximum.
  always_comb begin
    sum_w = SW'(credit_q) + (ev[4] ? SW'(1) : '0) + (ev[5] ? SW'(5) : '0)
          + (ev[6] ? SW'(10) : '0);
    sum_sat = (sum_w > SW'(CMAX)) ? CMAX : sum_w[CREDIT_W-1:0];
  end

  // Next-state, datapath and output-pulse decisions.
  always_comb begin
    state_d  = state_q;
    item_d   = item_q;
    credit_d = credit_q;
    tmo_d    = tmo_q;
    dcnt_d   = dcnt_q;
    c1_d     = 1'b0;
    c5_d     = 1'b0;
    c10_d    = 1'b0;
    case (state_q)
      IDLE: begin
        item_d = '0;
        if (ev[0]) state_d = SEL;
      end
      SEL: begin
        if (ev[3]) begin
          state_d = IDLE;
          item_d  = '0;
        end else if (ev[2]) begin
          state_d = PAY;
          tmo_d   = '0;
        end else if (ev[1]) begin
          item_d = (item_q == ITEM_W'(NUM_ITEMS - 1)) ? '0 : item_q + ITEM_W'(1);
        end
      end
      PAY: begin
        credit_d = sum_sat;
        tmo_d    = tmo_inc;
        if (ev[3] || (tmo_inc == TCW'(TIMEOUT_CYC))) begin
          state_d = CHANGE;
        end else if (sum_sat >= price_ext) begin
          state_d  = DISP;
          credit_d = sum_sat - price_ext;
          dcnt_d   = '0;
        end
      end
      DISP: begin
        if (dcnt_q == DCW'(DISPENSE_CYC - 1)) state_d = CHANGE;
        else dcnt_d = dcnt_q + DCW'(1);
      end
      CHANGE: begin
        if (credit_q >= CREDIT_W'(10)) begin
          c10_d    = 1'b1;
          credit_d = credit_q - CREDIT_W'(10);
        end else if (credit_q >= CREDIT_W'(5)) begin
          c5_d     = 1'b1;
          credit_d = credit_q - CREDIT_W'(5);
        end else if (credit_q != '0) begin
          c1_d     = 1'b1;
          credit_d = credit_q - CREDIT_W'(1);
        end else begin
          state_d = IDLE;
          item_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        item_d  = '0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset drops any held credit.
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      item_q   <= '0;
      credit_q <= '0;
      tmo_q    <= '0;
      dcnt_q   <= '0;
      disp_q   <= 1'b0;
      c1_q     <= 1'b0;
      c5_q     <= 1'b0;
      c10_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      item_q   <= item_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      dcnt_q   <= dcnt_d;
      disp_q   <= (state_d == DISP);
      c1_q     <= c1_d;
      c5_q     <= c5_d;
      c10_q    <= c10_d;
    end
  end

  assign ITEM     = item_q;
  assign CREDIT   = credit_q;
  assign DISPENSE = disp_q;
  assign C1       = c1_q;
  assign C5       = c5_q;
  assign C10      = c10_q;

endmodule

// File: tb/tb_vmc_param.sv
// Directed bench for vmc_param: one task per scenario, hand-computed expectations.
module tb_vmc_param;

  logic       CLOCK;
  logic       nRESET;
  logic [6:0] btn;
  logic [1:0] ITEM;
  logic [6:0] CREDIT;
  logic       DISPENSE, C1, C5, C10;

  localparam logic [6:0] B_START  = 7'h01;
  localparam logic [6:0] B_SELECT = 7'h02;
  localparam logic [6:0] B_OK     = 7'h04;
  localparam logic [6:0] B_CANCEL = 7'h08;
  localparam logic [6:0] B_C1     = 7'h10;
  localparam logic [6:0] B_C5     = 7'h20;
  localparam logic [6:0] B_C10    = 7'h40;

  vmc_param dut (
    .CLOCK    (CLOCK),
    .nRESET   (nRESET),
    .START    (btn[0]),
    .SELECT   (btn[1]),
    .OK       (btn[2]),
    .CANCEL   (btn[3]),
    .COIN_1   (btn[4]),
    .COIN_5   (btn[5]),
    .COIN_10  (btn[6]),
    .ITEM     (ITEM),
    .CREDIT   (CREDIT),
    .DISPENSE (DISPENSE),
    .C1       (C1),
    .C5       (C5),
    .C10      (C10)
  );

  // Clock generation
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Observations gathered on every sample point.
  int         cyc = 0;
  int         disp_cnt, disp_first, disp_last, multi_cnt;
  logic [2:0] got_q[$];   // {C10,C5,C1} per pulse
  int         got_cyc[$];

  task automatic clear_obs();
    disp_cnt   = 0;
    disp_first = -1;
    disp_last  = -1;
    multi_cnt  = 0;
    got_q.delete();
    got_cyc.delete();
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge CLOCK);
    #1;
    cyc++;
    if (DISPENSE) begin
      if (disp_first < 0) disp_first = cyc;
      disp_last = cyc;
      disp_cnt++;
    end
    if (C1 | C5 | C10) begin
      got_q.push_back({C10, C5, C1});
      got_cyc.push_back(cyc);
      if ((int'(C1) + int'(C5) + int'(C10)) > 1) multi_cnt++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raise the given switches for one cycle, release, and let the FSM react.
  task automatic press(input logic [6:0] m);
    btn = m;
    tick();
    btn = '0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    btn    = '0;
    ticks(3);
    nRESET = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_obs();
    do_reset();
    checks++; if (ITEM !== 2'd0) begin errors++; $display("FAIL reset_item got %0d exp 0", ITEM); end
    checks++; if (CREDIT !== 7'd0) begin errors++; $display("FAIL reset_credit got %0d exp 0", CREDIT); end
    checks++; if ({DISPENSE, C1, C5, C10} !== 4'b0) begin errors++; $display("FAIL reset_outs got %b exp 0000", {DISPENSE, C1, C5, C10}); end
  endtask

  task automatic test_exact_pay();
    // item 2 costs 25: 10 + 10 + 5, no change
    press(B_START); press(B_SELECT); press(B_SELECT);
    checks++; if (ITEM !== 2'd2) begin errors++; $display("FAIL exact_item got %0d exp 2", ITEM); end
    press(B_OK);
    press(B_C10);
    checks++; if (CREDIT !== 7'd10) begin errors++; $display("FAIL exact_credit10 got %0d exp 10", CREDIT); end
    press(B_C10);
    checks++; if (CREDIT !== 7'd20) begin errors++; $display("FAIL exact_credit20 got %0d exp 20", CREDIT); end
    clear_obs();
    press(B_C5);
    ticks(10);
    checks++; if (disp_cnt != 2) begin errors++; $display("FAIL exact_disp_cycles got %0d exp 2", disp_cnt); end
    checks++; if (disp_last - disp_first + 1 != 2) begin errors++; $display("FAIL exact_disp_contig got %0d exp 2", disp_last - disp_first + 1); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL exact_no_change got %0d exp 0", got_q.size()); end
    checks++; if (CREDIT !== 7'd0) begin errors++; $display("FAIL exact_credit_end got %0d exp 0", CREDIT); end
    checks++; if (ITEM !== 2'd0) begin errors++; $display("FAIL exact_idle_item got %0d exp 0", ITEM); end
  endtask

  task automatic test_change_c5();
    // item 0 costs 15: pay 20, expect one 5 back
    press(B_START); press(B_OK);
    press(B_C10);
    checks++; if (CREDIT !== 7'd10) begin errors++; $display("FAIL c5_credit got %0d exp 10", CREDIT); end
    clear_obs();
    press(B_C10);
    ticks(10);
    checks++; if (disp_cnt != 2) begin errors++; $display("FAIL c5_disp_cycles got %0d exp 2", disp_cnt); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL c5_count got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 3'b010) begin errors++; $display("FAIL c5_coin got %b exp 010", got_q[0]); end
      checks++; if (got_cyc[0] <= disp_last) begin errors++; $display("FAIL c5_order got %0d exp >%0d", got_cyc[0], disp_last); end
    end
    checks++; if (CREDIT !== 7'd0) begin errors++; $display("FAIL c5_credit_end got %0d exp 0", CREDIT); end
  endtask

  task automatic test_change_c1();
    // item 3 costs 7: 10+1 in one cycle = 11, expect four 1s
    press(B_START); press(B_SELECT); press(B_SELECT); press(B_SELECT);
    checks++; if (ITEM !== 2'd3) begin errors++; $display("FAIL c1_item got %0d exp 3", ITEM); end
    press(B_OK);
    clear_obs();
    press(B_C10 | B_C1);
    ticks(12);
    checks++; if (disp_cnt != 2) begin errors++; $display("FAIL c1_disp_cycles got %0d exp 2", disp_cnt); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL c1_count got %0d exp 4", got_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_q[i] !== 3'b001) begin errors++; $display("FAIL c1_coin[%0d] got %b exp 001", i, got_q[i]); end
      end
      checks++; if (got_cyc[3] - got_cyc[0] != 3) begin errors++; $display("FAIL c1_consecutive got %0d exp 3", got_cyc[3] - got_cyc[0]); end
      checks++; if (got_cyc[0] <= disp_last) begin errors++; $display("FAIL c1_order got %0d exp >%0d", got_cyc[0], disp_last); end
    end
    checks++; if (multi_cnt != 0) begin errors++; $display("FAIL c1_one_hot got %0d exp 0", multi_cnt); end
    checks++; if (ITEM !== 2'd0) begin errors++; $display("FAIL c1_idle_item got %0d exp 0", ITEM); end
  endtask

  task automatic test_select_wrap();
    press(B_START); press(B_SELECT); press(B_SELECT); press(B_SELECT);
    checks++; if (ITEM !== 2'd3) begin errors++; $display("FAIL wrap_pre got %0d exp 3", ITEM); end
    press(B_SELECT);
    checks++; if (ITEM !== 2'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", ITEM); end
    btn = B_SELECT;
    ticks(10);
    btn = '0;
    ticks(2);
    checks++; if (ITEM !== 2'd1) begin errors++; $display("FAIL held_select got %0d exp 1", ITEM); end
    clear_obs();
    press(B_CANCEL);
    ticks(3);
    checks++; if (ITEM !== 2'd0) begin errors++; $display("FAIL sel_cancel_item got %0d exp 0", ITEM); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL sel_cancel_change got %0d exp 0", got_q.size()); end
  endtask

  task automatic test_reset_mid_pay();
    press(B_START); press(B_SELECT); press(B_OK);
    press(B_C10); press(B_C1); press(B_C1);
    checks++; if (CREDIT !== 7'd12) begin errors++; $display("FAIL midpay_credit got %0d exp 12", CREDIT); end
    clear_obs();
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    checks++; if (CREDIT !== 7'd0) begin errors++; $display("FAIL midpay_rst_credit got %0d exp 0", CREDIT); end
    checks++; if (ITEM !== 2'd0) begin errors++; $display("FAIL midpay_rst_item got %0d exp 0", ITEM); end
    ticks(30);
    checks++; if (got_q.size() != 0 || disp_cnt != 0) begin errors++; $display("FAIL midpay_quiet got %0d/%0d exp 0/0", got_q.size(), disp_cnt); end
    checks++; if (CREDIT !== 7'd0) begin errors++; $display("FAIL midpay_credit_end got %0d exp 0", CREDIT); end
  endtask

  task automatic test_timeout();
    // item 1 costs 20; 6 paid then idle -> refund 5 + 1
    press(B_START); press(B_SELECT); press(B_OK);
    press(B_C5); press(B_C1);
    checks++; if (CREDIT !== 7'd6) begin errors++; $display("FAIL tmo_credit got %0d exp 6", CREDIT); end
    clear_obs();
    ticks(15);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL tmo_early got %0d exp 0", got_q.size()); end
    ticks(30);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL tmo_count got %0d exp 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 3'b010) begin errors++; $display("FAIL tmo_first got %b exp 010", got_q[0]); end
      checks++; if (got_q[1] !== 3'b001) begin errors++; $display("FAIL tmo_second got %b exp 001", got_q[1]); end
    end
    checks++; if (disp_cnt != 0) begin errors++; $display("FAIL tmo_no_disp got %0d exp 0", disp_cnt); end
    checks++; if (CREDIT !== 7'd0) begin errors++; $display("FAIL tmo_credit_end got %0d exp 0", CREDIT); end
  endtask

  task automatic test_cancel_with_coin();
    // credit 10, then CANCEL + COIN_10 together: 20 would buy item 1 but cancel wins
    press(B_START); press(B_SELECT); press(B_OK);
    press(B_C10);
    checks++; if (CREDIT !== 7'd10) begin errors++; $display("FAIL cancel_credit got %0d exp 10", CREDIT); end
    clear_obs();
    press(B_CANCEL | B_C10);
    ticks(10);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL cancel_count got %0d exp 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 3'b100 || got_q[1] !== 3'b100) begin errors++; $display("FAIL cancel_coins got %b,%b exp 100,100", got_q[0], got_q[1]); end
    end
    checks++; if (disp_cnt != 0) begin errors++; $display("FAIL cancel_no_disp got %0d exp 0", disp_cnt); end
    checks++; if (ITEM !== 2'd0) begin errors++; $display("FAIL cancel_idle_item got %0d exp 0", ITEM); end
  endtask

  // Test sequence and final report
  initial begin
    btn    = '0;
    nRESET = 1'b0;
    clear_obs();
    test_reset();
    test_exact_pay();
    test_change_c5();
    test_change_c1();
    test_select_wrap();
    test_reset_mid_pay();
    test_timeout();
    test_cancel_with_coin();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
